nv_nvdla_mcif_wr_arb: RTL and testbench

- Weighted round-robin command/data arbiter for the MCIF write ingress path. It shares the single AXI write channel between the SDP, PDP and CDP write clients.
- Grants one command at a time and locks the data path to the winner until its burst completes.
- Enforces the programmed outstanding-beat limit, using completion returns from the write egress block.
- Sits between the client request buffers and the AW/W packer. The payload mux is external and steered by dn_sel.

---
 rtl/nv_nvdla_mcif_wr_arb_pkg.sv | 22 ++
 rtl/nv_nvdla_mcif_wr_arb_if.sv | 40 ++++
 rtl/nv_nvdla_mcif_wr_arb_os_cnt.sv | 42 ++++
 rtl/nv_nvdla_mcif_wr_arb.sv | 158 +++++++++++++++
 tb/tb_nv_nvdla_mcif_wr_arb.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/nv_nvdla_mcif_wr_arb_pkg.sv
// Shared constants, state encoding and round-robin helper for the MCIF write
// ingress arbiter (SDP/PDP/CDP clients).
package nv_nvdla_mcif_wr_arb_pkg;
   localparam int NCLI = 3;
   localparam int LENW = 2;
   localparam int OSW  = 9;
   localparam int IDW  = 2;
   localparam int WW   = 8;

   localparam logic [IDW-1:0] CLI_SDP = 2'd0;
   localparam logic [IDW-1:0] CLI_PDP = 2'd1;
   localparam logic [IDW-1:0] CLI_CDP = 2'd2;

   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ARB  = 2'd0;
   localparam arb_state_t CMD  = 2'd1;
   localparam arb_state_t DATA = 2'd2;

   function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
      return (id >= IDW'(NCLI-1)) ? '0 : id + 1'b1;
   endfunction
endpackage

// File: rtl/nv_nvdla_mcif_wr_arb_if.sv
// Client, downstream, register and completion signals of the write arbiter.
// slave = arbiter view, master = surrounding logic view.
interface nv_nvdla_mcif_wr_arb_if;
   import nv_nvdla_mcif_wr_arb_pkg::*;

   logic [NCLI-1:0]      cl_cmd_vld;
   logic [NCLI*LENW-1:0] cl_cmd_len;
   logic [NCLI-1:0]      cl_cmd_rdy;
   logic [NCLI-1:0]      cl_dat_vld;
   logic [NCLI-1:0]      cl_dat_rdy;
   logic                 dn_cmd_vld;
   logic                 dn_cmd_rdy;
   logic [IDW-1:0]       dn_cmd_id;
   logic [LENW-1:0]      dn_cmd_len;
   logic                 dn_dat_vld;
   logic                 dn_dat_rdy;
   logic [IDW-1:0]       dn_sel;
   logic [WW-1:0]        reg2dp_wr_weight_sdp;
   logic [WW-1:0]        reg2dp_wr_weight_pdp;
   logic [WW-1:0]        reg2dp_wr_weight_cdp;
   logic [WW-1:0]        reg2dp_wr_os_cnt;
   logic                 eg2ig_axi_vld;
   logic [LENW-1:0]      eg2ig_axi_len;

   modport slave (
      input  cl_cmd_vld, cl_cmd_len, cl_dat_vld, dn_cmd_rdy, dn_dat_rdy,
             reg2dp_wr_weight_sdp, reg2dp_wr_weight_pdp, reg2dp_wr_weight_cdp,
             reg2dp_wr_os_cnt, eg2ig_axi_vld, eg2ig_axi_len,
      output cl_cmd_rdy, cl_dat_rdy, dn_cmd_vld, dn_cmd_id, dn_cmd_len,
             dn_dat_vld, dn_sel
   );

   modport master (
      output cl_cmd_vld, cl_cmd_len, cl_dat_vld, dn_cmd_rdy, dn_dat_rdy,
             reg2dp_wr_weight_sdp, reg2dp_wr_weight_pdp, reg2dp_wr_weight_cdp,
             reg2dp_wr_os_cnt, eg2ig_axi_vld, eg2ig_axi_len,
      input  cl_cmd_rdy, cl_dat_rdy, dn_cmd_vld, dn_cmd_id, dn_cmd_len,
             dn_dat_vld, dn_sel
   );
endinterface

// File: rtl/nv_nvdla_mcif_wr_arb_os_cnt.sv
// Outstanding-beat counter: adds issued bursts, subtracts completions (net in
// one cycle, floor at 0) and reports, per burst length, whether it still fits.
module nv_nvdla_mcif_wr_arb_os_cnt
   import nv_nvdla_mcif_wr_arb_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 issue_i,
   input  logic [LENW-1:0]      issue_len_i,
   input  logic                 cpl_i,
   input  logic [LENW-1:0]      cpl_len_i,
   input  logic [WW-1:0]        limit_i,
   output logic [OSW-1:0]       os_cnt_o,
   output logic [(1<<LENW)-1:0] fit_o
);
   logic [OSW-1:0] os_cnt_q, os_cnt_d;
   logic [OSW:0]   inc, dec, sum, lim;
   logic           underflow;

   always_comb begin
      inc       = issue_i ? (OSW+1)'(issue_len_i) + (OSW+1)'(1) : '0;
      dec       = cpl_i ? (OSW+1)'(cpl_len_i) + (OSW+1)'(1) : '0;
      sum       = (OSW+1)'(os_cnt_q) + inc;
      underflow = sum < dec;
      os_cnt_d  = underflow ? '0 : OSW'(sum - dec);
      lim       = (OSW+1)'(limit_i) + (OSW+1)'(1);
      fit_o     = '0;
      for (int l = 0; l < (1 << LENW); l++)
         fit_o[l] = ((OSW+1)'(os_cnt_q) + (OSW+1)'(l) + (OSW+1)'(1)) <= lim;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         os_cnt_q <= '0;
      end else begin
         os_cnt_q <= os_cnt_d;
         assert (!underflow);
      end
   end

   assign os_cnt_o = os_cnt_q;
endmodule

// File: rtl/nv_nvdla_mcif_wr_arb.sv
// Weighted round-robin write command/data arbiter for SDP/PDP/CDP.
// Optional NVDLA_MCIF_WR_ARB_STALL_CNT_EN adds dbg_os_stall_cnt.
module nv_nvdla_mcif_wr_arb
   import nv_nvdla_mcif_wr_arb_pkg::*;
(
   input  logic nvdla_core_clk,
   input  logic nvdla_core_rst,
`ifdef NVDLA_MCIF_WR_ARB_STALL_CNT_EN
   output logic [31:0] dbg_os_stall_cnt,
`endif
   nv_nvdla_mcif_wr_arb_if.slave bus
);
   arb_state_t           state_q, state_d;
   logic [IDW-1:0]       id_q, id_d, rr_q, rr_d, win, idx;
   logic [LENW-1:0]      len_q, len_d, beat_q, beat_d;
   logic [WW-1:0]        wcnt_q [NCLI];
   logic [WW-1:0]        wcnt_d [NCLI];
   logic [WW-1:0]        wreg   [NCLI];
   logic [WW-1:0]        eff_w  [NCLI];
   logic [LENW-1:0]      cli_len[NCLI];
   logic [NCLI-1:0]      fit, credit, elig, sel_oh, pend_q;
   logic [NCLI*LENW-1:0] plen_q;
   logic [(1<<LENW)-1:0] fit_len;
   logic [OSW-1:0]       os_cnt;
   logic                 reload, found, issue, beat_hs;

   assign wreg[CLI_SDP] = bus.reg2dp_wr_weight_sdp;
   assign wreg[CLI_PDP] = bus.reg2dp_wr_weight_pdp;
   assign wreg[CLI_CDP] = bus.reg2dp_wr_weight_cdp;

   assign issue   = (state_q == CMD) && bus.dn_cmd_rdy;
   assign beat_hs = (state_q == DATA) && bus.cl_dat_vld[id_q] && bus.dn_dat_rdy;
   assign sel_oh  = NCLI'(1) << id_q;

   nv_nvdla_mcif_wr_arb_os_cnt u_os (
      .clk_i       (nvdla_core_clk),
      .rst_i       (nvdla_core_rst),
      .issue_i     (issue),
      .issue_len_i (len_q),
      .cpl_i       (bus.eg2ig_axi_vld),
      .cpl_len_i   (bus.eg2ig_axi_len),
      .limit_i     (bus.reg2dp_wr_os_cnt),
      .os_cnt_o    (os_cnt),
      .fit_o       (fit_len)
   );

   // Reloaded weights are used in the same cycle they are loaded.
   always_comb begin
      credit = '0;
      fit    = '0;
      elig   = '0;
      for (int i = 0; i < NCLI; i++) begin
         cli_len[i] = bus.cl_cmd_len[i*LENW +: LENW];
         fit[i]     = fit_len[cli_len[i]];
         credit[i]  = bus.cl_cmd_vld[i] && (wcnt_q[i] != '0);
      end
      reload = (state_q == ARB) && (|bus.cl_cmd_vld) && !(|credit);
      for (int i = 0; i < NCLI; i++) begin
         eff_w[i] = !reload ? wcnt_q[i] : (wreg[i] == '0) ? WW'(1) : wreg[i];
         elig[i]  = bus.cl_cmd_vld[i] && (eff_w[i] != '0) && fit[i];
      end
      win   = '0;
      found = 1'b0;
      idx   = rr_q;
      for (int k = 0; k < NCLI; k++) begin
         if (!found && elig[idx]) begin
            win   = idx;
            found = 1'b1;
         end
         idx = rr_next(idx);
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      len_d   = len_q;
      beat_d  = beat_q;
      rr_d    = rr_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ARB: begin
            wcnt_d = eff_w;
            if (found) begin
               id_d    = win;
               len_d   = cli_len[win];
               state_d = CMD;
            end
         end
         CMD: begin
            if (issue) begin
               for (int i = 0; i < NCLI; i++)
                  if (IDW'(i) == id_q) wcnt_d[i] = wcnt_q[i] - 1'b1;
               rr_d    = rr_next(id_q);
               beat_d  = len_q;
               state_d = DATA;
            end
         end
         DATA: begin
            if (beat_hs) begin
               if (beat_q == '0) state_d = ARB;
               else              beat_d  = beat_q - 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state_q <= ARB;
         id_q    <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         rr_q    <= '0;
         pend_q  <= '0;
         plen_q  <= '0;
         for (int i = 0; i < NCLI; i++) wcnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         rr_q    <= rr_d;
         wcnt_q  <= wcnt_d;
         // A pending command must stay asserted with an unchanged length.
         for (int i = 0; i < NCLI; i++)
            if (pend_q[i])
               assert (bus.cl_cmd_vld[i] &&
                       (bus.cl_cmd_len[i*LENW +: LENW] == plen_q[i*LENW +: LENW]));
         assert (os_cnt <= OSW'(1 << WW));
         pend_q  <= bus.cl_cmd_vld & ~bus.cl_cmd_rdy;
         plen_q  <= bus.cl_cmd_len;
      end
   end

   assign bus.dn_cmd_vld = (state_q == CMD);
   assign bus.dn_cmd_id  = id_q;
   assign bus.dn_cmd_len = len_q;
   assign bus.dn_sel     = id_q;
   assign bus.cl_cmd_rdy = issue ? sel_oh : '0;
   assign bus.dn_dat_vld = (state_q == DATA) && bus.cl_dat_vld[id_q];
   assign bus.cl_dat_rdy = ((state_q == DATA) && bus.dn_dat_rdy) ? sel_oh : '0;

`ifdef NVDLA_MCIF_WR_ARB_STALL_CNT_EN
   logic [31:0] stall_q;
   logic        stall;

   assign stall = (state_q == ARB) && (|bus.cl_cmd_vld) && !(|(bus.cl_cmd_vld & fit));

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst)                 stall_q <= '0;
      else if (stall && (stall_q != '1))  stall_q <= stall_q + 32'd1;
   end

   assign dbg_os_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_nv_nvdla_mcif_wr_arb.sv
// Directed bench for nv_nvdla_mcif_wr_arb: grant order scoreboard, os limit,
// net issue/completion, data steering and mid-burst reset.
module tb_nv_nvdla_mcif_wr_arb;
   import nv_nvdla_mcif_wr_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   last_hs = -1;
   int   beats;
   int   exp_q[$];
`ifdef NVDLA_MCIF_WR_ARB_STALL_CNT_EN
   logic [31:0] dbg;
`endif

   nv_nvdla_mcif_wr_arb_if bus();

   nv_nvdla_mcif_wr_arb dut (
      .nvdla_core_clk   (clk),
      .nvdla_core_rst   (rst),
`ifdef NVDLA_MCIF_WR_ARB_STALL_CNT_EN
      .dbg_os_stall_cnt (dbg),
`endif
      .bus              (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.cl_cmd_vld    = '0;
      bus.eg2ig_axi_vld = 1'b0;
      bus.dn_cmd_rdy    = 1'b1;
      bus.dn_dat_rdy    = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic chk_idle(input string p);
      chk({p, "_dn_cmd_vld"}, bus.dn_cmd_vld, 0);
      chk({p, "_dn_dat_vld"}, bus.dn_dat_vld, 0);
      chk({p, "_cl_cmd_rdy"}, bus.cl_cmd_rdy, 0);
      chk({p, "_cl_dat_rdy"}, bus.cl_dat_rdy, 0);
      chk({p, "_dn_cmd_id"},  bus.dn_cmd_id, 0);
      chk({p, "_dn_cmd_len"}, bus.dn_cmd_len, 0);
      chk({p, "_dn_sel"},     bus.dn_sel, 0);
      chk({p, "_state"},      dut.state_q, ARB);
      chk({p, "_os_cnt"},     dut.u_os.os_cnt_q, 0);
`ifdef NVDLA_MCIF_WR_ARB_STALL_CNT_EN
      chk({p, "_stall_cnt"},  dbg, 0);
`endif
   endtask

   // Pops the scoreboard on every downstream command handshake.
   task automatic mon(input int len);
      int e;
      if (bus.dn_cmd_vld && bus.dn_cmd_rdy) begin
         n_chk++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL grant_unexpected: observed id %0d, expected no grant", bus.dn_cmd_id);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("grant_id",  bus.dn_cmd_id, e);
            chk("grant_len", bus.dn_cmd_len, len);
            chk("grant_cl_cmd_rdy", bus.cl_cmd_rdy, 64'(1) << e);
            if (last_hs >= 0) chk("burst_period", cyc - last_hs, len + 3);
            last_hs = cyc;
         end
      end
   endtask

   task automatic run_grants(input int len, input int budget);
      last_hs = -1;
      for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
         tick();
         settle();
         mon(len);
      end
      chk("grant_queue_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      bus.cl_cmd_vld           = '0;
      bus.cl_cmd_len           = '0;
      bus.cl_dat_vld           = '0;
      bus.dn_cmd_rdy           = 1'b1;
      bus.dn_dat_rdy           = 1'b1;
      bus.reg2dp_wr_weight_sdp = 8'd1;
      bus.reg2dp_wr_weight_pdp = 8'd1;
      bus.reg2dp_wr_weight_cdp = 8'd1;
      bus.reg2dp_wr_os_cnt     = 8'd255;
      bus.eg2ig_axi_vld        = 1'b0;
      bus.eg2ig_axi_len        = '0;

      // reset state, during and after reset
      tick(); tick(); settle();
      chk_idle("in_rst");
      rst = 1'b0;
      tick(); settle();
      chk_idle("post_rst");

      // weights 1/1/1, len 0, all clients requesting
      bus.cl_cmd_vld = 3'b111;
      bus.cl_dat_vld = 3'b111;
      bus.cl_cmd_len = 6'b000000;
      exp_q = '{0, 1, 2, 0, 1, 2};
      run_grants(0, 60);
      do_reset();

      // weights 3/1/2, len 3; seventh grant shows the reload
      bus.reg2dp_wr_weight_sdp = 8'd3;
      bus.reg2dp_wr_weight_pdp = 8'd1;
      bus.reg2dp_wr_weight_cdp = 8'd2;
      bus.cl_cmd_len = 6'b111111;
      bus.cl_cmd_vld = 3'b111;
      exp_q = '{0, 1, 2, 0, 2, 0, 1};
      run_grants(3, 120);
      do_reset();

      // outstanding limit 4 beats, client 0 len 3
      bus.reg2dp_wr_weight_sdp = 8'd1;
      bus.reg2dp_wr_weight_pdp = 8'd1;
      bus.reg2dp_wr_weight_cdp = 8'd1;
      bus.reg2dp_wr_os_cnt = 8'd3;
      bus.cl_cmd_len = 6'b000011;
      bus.cl_cmd_vld = 3'b001;
      bus.cl_dat_vld = 3'b001;
      exp_q = '{0};
      run_grants(3, 20);
      for (int c = 0; c < 6; c++) tick();
      settle();
      chk("t3_hold_state", dut.state_q, ARB);
      chk("t3_hold_os", dut.u_os.os_cnt_q, 4);
      chk("t3_hold_cl_cmd_rdy", bus.cl_cmd_rdy, 0);
      for (int c = 0; c < 3; c++) begin
         tick(); settle();
         chk("t3_hold_cmd_vld", bus.dn_cmd_vld, 0);
      end
`ifdef NVDLA_MCIF_WR_ARB_STALL_CNT_EN
      chk("t3_stall_cnt_nz", dbg != 32'd0, 1);
`endif
      bus.eg2ig_axi_vld = 1'b1;
      bus.eg2ig_axi_len = 2'd3;
      tick();
      bus.eg2ig_axi_vld = 1'b0;
      settle();
      chk("t3_cpl_cmd_vld", bus.dn_cmd_vld, 0);
      chk("t3_cpl_os", dut.u_os.os_cnt_q, 0);
      tick(); settle();
      chk("t3_release_cmd_vld", bus.dn_cmd_vld, 1);
      chk("t3_release_id", bus.dn_cmd_id, 0);
      chk("t3_release_len", bus.dn_cmd_len, 3);
      do_reset();

      // issue len 1 and completion len 1 in the same cycle at os_cnt 2
      bus.reg2dp_wr_os_cnt = 8'd255;
      bus.cl_cmd_len = 6'b000100;
      bus.cl_cmd_vld = 3'b010;
      bus.cl_dat_vld = 3'b010;
      exp_q = '{1};
      run_grants(1, 20);
      for (int c = 0; c < 20; c++) begin
         tick(); settle();
         if (bus.dn_cmd_vld) break;
      end
      chk("t4_second_cmd_vld", bus.dn_cmd_vld, 1);
      chk("t4_os_before", dut.u_os.os_cnt_q, 2);
      bus.eg2ig_axi_vld = 1'b1;
      bus.eg2ig_axi_len = 2'd1;
      tick();
      bus.eg2ig_axi_vld = 1'b0;
      settle();
      chk("t4_os_net", dut.u_os.os_cnt_q, 2);
      chk("t4_state", dut.state_q, DATA);
      bus.eg2ig_axi_vld = 1'b1;
      tick();
      bus.eg2ig_axi_vld = 1'b0;
      settle();
      chk("t4_os_cpl_only", dut.u_os.os_cnt_q, 0);
      do_reset();

      // data steering with toggling dn_dat_rdy, client 2 len 3
      bus.cl_cmd_len = 6'b110000;
      bus.cl_cmd_vld = 3'b100;
      bus.cl_dat_vld = 3'b111;
      for (int c = 0; c < 20; c++) begin
         tick(); settle();
         if (bus.cl_cmd_rdy[2]) break;
      end
      chk("t5_cmd_rdy", bus.cl_cmd_rdy, 3'b100);
      tick();
      bus.cl_cmd_vld = '0;
      beats = 0;
      for (int c = 0; c < 30 && dut.state_q == DATA; c++) begin
         bus.dn_dat_rdy = c[0];
         settle();
         chk("t5_cl_dat_rdy", bus.cl_dat_rdy, c[0] ? 3'b100 : 3'b000);
         chk("t5_dn_dat_vld", bus.dn_dat_vld, 1);
         chk("t5_dn_sel", bus.dn_sel, 2);
         if (bus.dn_dat_rdy) beats++;
         tick();
      end
      settle();
      chk("t5_beats", beats, 4);
      chk("t5_state_end", dut.state_q, ARB);
      do_reset();

      // reset in DATA with beat_cnt 2
      bus.cl_cmd_len = 6'b000011;
      bus.cl_cmd_vld = 3'b001;
      bus.cl_dat_vld = 3'b001;
      for (int c = 0; c < 20; c++) begin
         tick(); settle();
         if (dut.state_q == DATA && dut.beat_q == 2'd2) break;
      end
      chk("t6_beat_cnt", dut.beat_q, 2);
      rst = 1'b1;
      tick(); settle();
      chk_idle("t6_rst");
      bus.cl_cmd_vld = '0;
      rst = 1'b0;
      tick(); settle();
      chk_idle("t6_post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
